// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared constants for the ALU arbiter slice.
//   - OP_* : ALU control encoding, identical to what the ALU itself decodes
//   - state_t : arbiter FSM states
//   - W_DEF : default operand/result width
package alu_arb_pkg;

  localparam int W_DEF = 32;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant.
//   req[1:0]   : request vector, bit N = port N
//   last_grant : port served most recently
//   gnt[1:0]   : one-hot grant (all zero when nothing requests)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // Contention: favour whichever port was not served last.
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   clk, reset            : clock, synchronous active-high reset
//   reqN_valid/ready      : request handshake (ready only in IDLE, granted port)
//   reqN_a/b/op           : operands and op, sampled on the handshake edge
//   alu_busA/busB/ctr     : registered ALU inputs, change only at acceptance
//   alu_out               : ALU result, combinational from alu_bus*/alu_ctr
//   rspN_valid/ready      : response handshake for the granted port
//   rspN_data/err         : result; err marks the reserved op (data forced to 0)
// One transaction in flight: IDLE -> EXEC -> RESP -> IDLE.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [1:0]   req0_op,
  input  logic [1:0]   req1_op,
  output logic [W-1:0] alu_busA,
  output logic [W-1:0] alu_busB,
  output logic [1:0]   alu_ctr,
  input  logic [W-1:0] alu_out,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  input  logic         rsp0_ready,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp0_data,
  output logic [W-1:0] rsp1_data,
  output logic         rsp0_err,
  output logic         rsp1_err
);

  state_t       state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic         port_q, port_d;         // port owning the in-flight transaction
  logic [W-1:0] busa_q, busa_d;
  logic [W-1:0] busb_q, busb_d;
  logic [1:0]   ctr_q, ctr_d;
  logic [W-1:0] res_q, res_d;
  logic         err_q, err_d;

  logic [1:0]   gnt;
  logic         in_idle, in_resp, rsp_hs;

  rr_arb2 u_rr (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  assign in_idle    = (state_q == IDLE);
  assign in_resp    = (state_q == RESP);
  assign req0_ready = in_idle & gnt[0];
  assign req1_ready = in_idle & gnt[1];
  assign rsp_hs     = in_resp & (port_q ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    busa_d       = busa_q;
    busb_d       = busb_q;
    ctr_d        = ctr_q;
    res_d        = res_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          port_d  = gnt[1];
          busa_d  = gnt[1] ? req1_a  : req0_a;
          busb_d  = gnt[1] ? req1_b  : req0_b;
          ctr_d   = gnt[1] ? req1_op : req0_op;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Reserved op still reaches the ALU as 11, but its output is discarded.
        if (ctr_q == OP_RSV) begin
          res_d = '0;
          err_d = 1'b1;
        end else begin
          res_d = alu_out;
          err_d = 1'b0;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          last_grant_d = port_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;   // port 0 wins the first contention
      port_q       <= 1'b0;
      busa_q       <= '0;
      busb_q       <= '0;
      ctr_q        <= 2'b00;
      res_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      busa_q       <= busa_d;
      busb_q       <= busb_d;
      ctr_q        <= ctr_d;
      res_q        <= res_d;
      err_q        <= err_d;
    end
  end

  assign alu_busA = busa_q;
  assign alu_busB = busb_q;
  assign alu_ctr  = ctr_q;

  // Response outputs are gated so the idle port always reads zero.
  assign rsp0_valid = in_resp & ~port_q;
  assign rsp1_valid = in_resp &  port_q;
  assign rsp0_data  = rsp0_valid ? res_q : '0;
  assign rsp1_data  = rsp1_valid ? res_q : '0;
  assign rsp0_err   = rsp0_valid & err_q;
  assign rsp1_err   = rsp1_valid & err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter. Accepted requests push an
// expected {port,data,err} entry; completed responses pop and compare it.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] alu_busA, alu_busB, alu_out;
  logic [1:0]   alu_ctr;
  logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [W-1:0] rsp0_data, rsp1_data;
  logic         rsp0_err, rsp1_err;

  always #5 clk = ~clk;

  // Stand-in for the shared ALU; reserved op yields junk the DUT must discard.
  always_comb begin
    case (alu_ctr)
      OP_ADD:  alu_out = alu_busA + alu_busB;
      OP_SUB:  alu_out = alu_busA - alu_busB;
      OP_OR:   alu_out = alu_busA | alu_busB;
      default: alu_out = 32'hDEAD_BEEF;
    endcase
  end

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .alu_busA(alu_busA), .alu_busB(alu_busB), .alu_ctr(alu_ctr), .alu_out(alu_out),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp0_data(rsp0_data), .rsp1_data(rsp1_data),
    .rsp0_err(rsp0_err), .rsp1_err(rsp1_err)
  );

  typedef struct packed { logic port; logic [W-1:0] data; logic err; } exp_t;
  exp_t         sb[$];
  logic         grant_log[$];
  logic [W-1:0] rsp_log[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic p, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] op);
    exp_t e;
    e.port = p;
    e.err  = 1'b0;
    case (op)
      2'b00:   e.data = a + b;
      2'b01:   e.data = a - b;
      2'b10:   e.data = a | b;
      default: begin e.data = '0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic pop_rsp(input logic p, input logic [W-1:0] d, input logic e);
    exp_t x;
    chk("rsp_expected", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("rsp_port", 32'(p), 32'(x.port));
      chk("rsp_data", d, x.data);
      chk("rsp_err", 32'(e), 32'(x.err));
    end
    rsp_log.push_back(d);
  endtask

  // Monitor: push on request handshake, pop on response handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (req0_valid && req0_ready) begin
        sb.push_back(model(1'b0, req0_a, req0_b, req0_op));
        grant_log.push_back(1'b0);
      end
      if (req1_valid && req1_ready) begin
        sb.push_back(model(1'b1, req1_a, req1_b, req1_op));
        grant_log.push_back(1'b1);
      end
      if (rsp0_valid && rsp0_ready) pop_rsp(1'b0, rsp0_data, rsp0_err);
      if (rsp1_valid && rsp1_ready) pop_rsp(1'b1, rsp1_data, rsp1_err);
      if (rsp0_valid && rsp1_valid) chk("rsp_both_valid", 32'(rsp0_valid & rsp1_valid), 0);
    end
  end

  task automatic do_txn(input logic p, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op, output logic [W-1:0] d, output logic e);
    int n;
    if (!p) begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
    else    begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
    n = 0;
    @(negedge clk);
    while (!(p ? req1_ready : req0_ready) && n < 20) begin @(negedge clk); n++; end
    chk("txn_accept", 32'(n < 20), 1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    n = 0;
    @(negedge clk);
    while (!(p ? rsp1_valid : rsp0_valid) && n < 20) begin @(negedge clk); n++; end
    chk("txn_latency", 32'(n), 1);   // one EXEC cycle, then valid
    d = p ? rsp1_data : rsp0_data;
    e = p ? rsp1_err  : rsp0_err;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("drain", 32'(sb.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rsp0v"}, 32'(rsp0_valid), 0);
    chk({tag, "_rsp1v"}, 32'(rsp1_valid), 0);
    chk({tag, "_busA"}, alu_busA, 0);
    chk({tag, "_busB"}, alu_busB, 0);
    chk({tag, "_ctr"}, 32'(alu_ctr), 0);
    chk({tag, "_rdy0"}, 32'(req0_ready), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] d;
    logic         e;
    int           n;

    reset = 1; req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; req0_op = 0; req1_op = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_zero("reset");
    chk("reset_rdy1", 32'(req1_ready), 0);
    chk("reset_err", 32'(rsp0_err | rsp1_err), 0);
    @(posedge clk); #1;
    reset = 0;

    // Single request on port 0: ADD 5+7.
    req0_valid = 1; req0_a = 5; req0_b = 7; req0_op = OP_ADD;
    @(negedge clk);
    chk("t1_rdy0", 32'(req0_ready), 1);
    chk("t1_rdy1", 32'(req1_ready), 0);
    @(posedge clk); #1;
    req0_valid = 0;
    @(negedge clk);
    chk("t1_ctr", 32'(alu_ctr), 32'(OP_ADD));
    chk("t1_busA", alu_busA, 5);
    chk("t1_busB", alu_busB, 7);
    chk("t1_exec_rsp0v", 32'(rsp0_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_rsp0v", 32'(rsp0_valid), 1);
    chk("t1_data", rsp0_data, 12);
    chk("t1_rsp1v", 32'(rsp1_valid), 0);
    @(posedge clk); #1;

    // Fresh reset so port 0 wins the first contention.
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    grant_log.delete(); rsp_log.delete(); sb.delete();

    // Contention with continuous re-requests.
    req0_valid = 1; req0_a = 3;     req0_b = 5;     req0_op = OP_SUB;
    req1_valid = 1; req1_a = 'hF0;  req1_b = 'h0F;  req1_op = OP_OR;
    for (n = 0; n < 40 && grant_log.size() < 4; n++) @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    drain();
    chk("cont_grants", 32'(grant_log.size()), 4);
    for (int i = 0; i < grant_log.size() && i < 4; i++)
      chk("cont_order", 32'(grant_log[i]), 32'(i % 2));
    chk("cont_rsp_cnt", 32'(rsp_log.size()), 4);
    if (rsp_log.size() >= 2) begin
      chk("cont_first", rsp_log[0], 32'hFFFF_FFFE);
      chk("cont_second", rsp_log[1], 32'h0000_00FF);
    end

    // Back-pressure on port 1 while port 0 waits.
    rsp1_ready = 0;
    req1_valid = 1; req1_a = 100; req1_b = 1; req1_op = OP_SUB;
    @(negedge clk);
    chk("bp_rdy1", 32'(req1_ready), 1);
    @(posedge clk); #1;
    req1_valid = 0;
    req0_valid = 1; req0_a = 9; req0_b = 9; req0_op = OP_ADD;
    @(negedge clk);
    chk("bp_exec_rdy0", 32'(req0_ready), 0);
    @(posedge clk); #1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_rsp1v", 32'(rsp1_valid), 1);
      chk("bp_rsp1d", rsp1_data, 99);
      chk("bp_rdy0", 32'(req0_ready), 0);
      @(posedge clk); #1;
    end
    rsp1_ready = 1;
    @(negedge clk);
    chk("bp_hs_rdy0", 32'(req0_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_after_rdy0", 32'(req0_ready), 1);
    @(posedge clk); #1;
    req0_valid = 0;
    drain();

    // Reserved op, then a normal op on the same port.
    do_txn(1'b1, 1, 1, OP_RSV, d, e);
    chk("rsv_data", d, 0);
    chk("rsv_err", 32'(e), 1);
    do_txn(1'b1, 2, 3, OP_ADD, d, e);
    chk("rsv_next_data", d, 5);
    chk("rsv_next_err", 32'(e), 0);

    // Reset while in EXEC.
    req0_valid = 1; req0_a = 10; req0_b = 20; req0_op = OP_ADD;
    @(negedge clk);
    chk("rx_rdy0", 32'(req0_ready), 1);
    @(posedge clk); #1;
    req0_valid = 0; reset = 1;
    @(posedge clk); #1;
    reset = 0; sb.delete();
    @(negedge clk);
    chk_zero("rx");
    repeat (3) begin
      @(negedge clk);
      chk("rx_no_rsp", 32'(rsp0_valid | rsp1_valid), 0);
    end
    @(posedge clk); #1;
    do_txn(1'b0, 30, 12, OP_ADD, d, e);
    chk("rx_after", d, 42);

    // Reset while in RESP (response held so it cannot complete first).
    rsp0_ready = 0;
    req0_valid = 1; req0_a = 1; req0_b = 2; req0_op = OP_OR;
    @(negedge clk);
    chk("rr_rdy0", 32'(req0_ready), 1);
    @(posedge clk); #1;
    req0_valid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rr_rsp0v", 32'(rsp0_valid), 1);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0; sb.delete(); rsp0_ready = 1;
    @(negedge clk);
    chk_zero("rr");
    repeat (3) begin
      @(negedge clk);
      chk("rr_no_rsp", 32'(rsp0_valid | rsp1_valid), 0);
    end
    @(posedge clk); #1;
    do_txn(1'b1, 7, 8, OP_OR, d, e);
    chk("rr_after", d, 15);

    // Modulo-2^W wrap.
    do_txn(1'b0, 32'hFFFF_FFFF, 1, OP_ADD, d, e);
    chk("wrap_add", d, 0);
    do_txn(1'b1, 0, 1, OP_SUB, d, e);
    chk("wrap_sub", d, 32'hFFFF_FFFF);

    repeat (2) @(posedge clk);
    chk("final_sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
